elbeth_lsu: RTL and testbench

Load/store unit: the initiator side of the ELBETH single-port memory handshake (enable / addr / byte-strobe write / registered ready). It sits between the core's execute stage and one port of the dual-port data memory. It takes byte/half/word load and store requests and turns each into one memory transaction. It steers write bytes onto lanes, extracts and sign/zero-extends read data, and reports misaligned, out-of-range and timed-out accesses.

---
 rtl/elbeth_lsu_pkg.sv | 27 ++
 rtl/elbeth_lsu_align.sv | 49 ++++
 rtl/elbeth_lsu.sv | 151 +++++++++++++++
 tb/tb_elbeth_lsu.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/elbeth_lsu_pkg.sv
// Shared encodings for the ELBETH load/store unit.
package elbeth_lsu_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_ILL  = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_DONE = 2'b10
    } lsu_state_e;

    // Illegal size counts as a fault alongside misalignment.
    function automatic logic lsu_bad_shape(logic [1:0] size, logic [1:0] a);
        case (size)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return a[0];
            MEM_WORD: return |a;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/elbeth_lsu_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
module elbeth_lsu_align
    import elbeth_lsu_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wr_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {addr_i, 3'b000};

    always_comb begin
        wr_o    = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (size_i)
            MEM_BYTE: begin
                wr_o    = 4'b0001 << addr_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = unsigned_i ? {24'b0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            end
            MEM_HALF: begin
                wr_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = unsigned_i ? {16'b0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
            end
            MEM_WORD: begin
                wr_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
            default: begin
                wr_o    = 4'b0000;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/elbeth_lsu.sv
// Load/store unit: one memory transaction per request, with
// alignment, range and timeout fault reporting.
module elbeth_lsu
    import elbeth_lsu_pkg::*;
#(
    parameter int AW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lsu_req,
    input  logic          lsu_we,
    input  logic [1:0]    lsu_size,
    input  logic          lsu_unsigned,
    input  logic [31:0]   lsu_addr,
    input  logic [31:0]   lsu_wdata,
    output logic          lsu_busy,
    output logic          lsu_done,
    output logic          lsu_err,
    output logic [31:0]   lsu_rdata,
    output logic          mem_enable,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wr,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_e    state_q, state_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          we_q, we_d;
    logic          uns_q, uns_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          first_q, first_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [3:0]    al_wr;
    logic [31:0]   al_rdata;
    logic          fault;

    elbeth_lsu_align u_align (
        .addr_i     (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_rdata),
        .wr_o       (al_wr),
        .wdata_o    (mem_wdata),
        .rdata_o    (al_rdata)
    );

    assign fault = lsu_bad_shape(lsu_size, lsu_addr[1:0])
                 | (|(lsu_addr >> (AW + 2)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        we_d       = we_q;
        uns_d      = uns_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        first_d    = 1'b0;
        err_d      = err_q;
        rdata_d    = rdata_q;
        mem_enable = 1'b0;
        mem_wr     = 4'b0000;
        case (state_q)
            S_IDLE: begin
                if (lsu_req) begin
                    addr_d  = lsu_addr[AW+1:0];
                    size_d  = lsu_size;
                    we_d    = lsu_we;
                    uns_d   = lsu_unsigned;
                    wdata_d = lsu_wdata;
                    if (fault) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = '0;
                        first_d = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                mem_enable = 1'b1;
                // Strobes only on the first cycle so a slow memory
                // never sees the write twice.
                if (first_q && we_q) begin
                    mem_wr = al_wr;
                end
                cnt_d = cnt_q + 1'b1;
                if (mem_ready) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d = al_rdata;
                    end
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_addr  = addr_q[AW+1:2];
    assign lsu_busy  = (state_q != S_IDLE);
    assign lsu_done  = (state_q == S_DONE);
    assign lsu_err   = err_q;
    assign lsu_rdata = rdata_q;

endmodule

// File: tb/tb_elbeth_lsu.sv
// Scoreboard bench for elbeth_lsu against a registered-ready memory.
module tb_elbeth_lsu;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lsu_req = 1'b0;
    logic          lsu_we = 1'b0;
    logic [1:0]    lsu_size = 2'b00;
    logic          lsu_unsigned = 1'b0;
    logic [31:0]   lsu_addr = '0;
    logic [31:0]   lsu_wdata = '0;
    logic          lsu_busy, lsu_done, lsu_err;
    logic [31:0]   lsu_rdata;
    logic          mem_enable;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wr;
    wire  [31:0]   mem_rdata;
    logic          mem_ready;

    elbeth_lsu #(.AW(AW), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .lsu_req      (lsu_req),
        .lsu_we       (lsu_we),
        .lsu_size     (lsu_size),
        .lsu_unsigned (lsu_unsigned),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .lsu_busy     (lsu_busy),
        .lsu_done     (lsu_done),
        .lsu_err      (lsu_err),
        .lsu_rdata    (lsu_rdata),
        .mem_enable   (mem_enable),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wr       (mem_wr),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    // Memory model: registered ready and read data, Z when not ready.
    logic [31:0] mem [0:255];
    logic [31:0] rd_q;
    logic        ready_q;
    logic        stuck = 1'b0;
    bit          init_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            ready_q <= mem_enable & ~stuck;
            if (mem_enable) rd_q <= mem[mem_addr];
        end
    end

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[0]    <= 32'h8899AABB;
            init_done <= 1'b1;
        end else if (mem_enable) begin
            for (int b = 0; b < 4; b++)
                if (mem_wr[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = ready_q ? rd_q : 32'hzzzz_zzzz;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          en;
        int          wrc;
        logic [3:0]  wr;
        logic [31:0] wdata;
        int          t0;
    } exp_t;

    exp_t q[$];

    int          en_cnt = 0;
    int          wr_cnt = 0;
    logic [3:0]  last_wr = '0;
    logic [31:0] last_wdata = '0;

    always @(negedge clk) begin
        if (rst) begin
            en_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (mem_enable) en_cnt++;
            if (mem_wr != 4'b0000) begin
                wr_cnt++;
                last_wr    = mem_wr;
                last_wdata = mem_wdata;
            end
            if (lsu_done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 want none");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.name, ".err"}, {31'b0, lsu_err}, {31'b0, e.err});
                    chk({e.name, ".rdata"}, lsu_rdata, e.rdata);
                    chk({e.name, ".lat"}, cyc - e.t0, e.lat);
                    chk({e.name, ".en_cycles"}, en_cnt, e.en);
                    chk({e.name, ".wr_cycles"}, wr_cnt, e.wrc);
                    if (e.wrc > 0) begin
                        chk({e.name, ".mem_wr"}, {28'b0, last_wr}, {28'b0, e.wr});
                        chk({e.name, ".mem_wdata"}, last_wdata, e.wdata);
                    end
                end
                en_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    task automatic issue(input string n, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wd, input logic eerr,
                         input logic [31:0] erd, input int lat, input int en,
                         input logic [3:0] ewr, input logic [31:0] ewd,
                         input int hold);
        exp_t e;
        int   k;
        @(negedge clk);
        lsu_we       = we;
        lsu_size     = sz;
        lsu_unsigned = uns;
        lsu_addr     = addr;
        lsu_wdata    = wd;
        lsu_req      = 1'b1;
        e.name  = n;
        e.err   = eerr;
        e.rdata = erd;
        e.lat   = lat;
        e.en    = en;
        e.wrc   = (ewr != 4'b0000) ? 1 : 0;
        e.wr    = ewr;
        e.wdata = ewd;
        e.t0    = cyc;
        q.push_back(e);
        repeat (hold) @(negedge clk);
        lsu_req = 1'b0;
        k = 0;
        while (lsu_busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (lsu_busy) begin
            checks++;
            errors++;
            $display("FAIL %s.wait: got busy=1 want idle within 40 cycles", n);
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s.no_done: got pending=%0d want 0", n, q.size());
            q.delete();
        end
    endtask

    initial begin
        #1;
        chk("rst.busy", {31'b0, lsu_busy}, 32'd0);
        chk("rst.done", {31'b0, lsu_done}, 32'd0);
        chk("rst.err", {31'b0, lsu_err}, 32'd0);
        chk("rst.rdata", lsu_rdata, 32'd0);
        chk("rst.enable", {31'b0, mem_enable}, 32'd0);
        chk("rst.wr", {28'b0, mem_wr}, 32'd0);
        chk("rst.addr", {24'b0, mem_addr}, 32'd0);
        chk("rst.wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        issue("lw0",   0, 2'b10, 0, 32'h0, 0, 0, 32'h8899AABB, 3, 2, 4'b0, 0, 1);
        issue("lb1",   0, 2'b00, 0, 32'h1, 0, 0, 32'hFFFFFFAA, 3, 2, 4'b0, 0, 1);
        issue("lbu1",  0, 2'b00, 1, 32'h1, 0, 0, 32'h000000AA, 3, 2, 4'b0, 0, 1);
        issue("lh2",   0, 2'b01, 0, 32'h2, 0, 0, 32'hFFFF8899, 3, 2, 4'b0, 0, 1);
        issue("sh6",   1, 2'b01, 0, 32'h6, 32'h00001234, 0, 32'hFFFF8899,
              3, 2, 4'b1100, 32'h12341234, 1);
        issue("lw4",   0, 2'b10, 0, 32'h4, 0, 0, 32'h12340000, 3, 2, 4'b0, 0, 1);
        issue("flw2",  0, 2'b10, 0, 32'h2, 0, 1, 32'h12340000, 1, 0, 4'b0, 0, 1);
        issue("fsh3",  1, 2'b01, 0, 32'h3, 32'hFFFF, 1, 32'h12340000,
              1, 0, 4'b0, 0, 1);
        issue("frng",  0, 2'b10, 0, 32'h400, 0, 1, 32'h12340000,
              1, 0, 4'b0, 0, 1);
        issue("fsize", 0, 2'b11, 0, 32'h0, 0, 1, 32'h12340000, 1, 0, 4'b0, 0, 1);
        issue("sb5",   1, 2'b00, 0, 32'h5, 32'h000000AB, 0, 32'h12340000,
              3, 2, 4'b0010, 32'hABABABAB, 1);
        issue("lw4b",  0, 2'b10, 0, 32'h4, 0, 0, 32'h1234AB00, 3, 2, 4'b0, 0, 3);

        stuck = 1'b1;
        issue("tmo",   0, 2'b10, 0, 32'h0, 0, 1, 32'h1234AB00, 17, 16, 4'b0, 0, 1);
        chk("tmo.enable_after", {31'b0, mem_enable}, 32'd0);
        stuck = 1'b0;
        @(negedge clk);
        issue("lbu7",  0, 2'b00, 1, 32'h7, 0, 0, 32'h00000012, 3, 2, 4'b0, 0, 1);

        @(negedge clk);
        lsu_we    = 1'b1;
        lsu_size  = 2'b10;
        lsu_addr  = 32'h0;
        lsu_wdata = 32'hDEADBEEF;
        lsu_req   = 1'b1;
        @(posedge clk);
        #1;
        lsu_req = 1'b0;
        chk("rstw.pre_enable", {31'b0, mem_enable}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstw.enable", {31'b0, mem_enable}, 32'd0);
        chk("rstw.wr", {28'b0, mem_wr}, 32'd0);
        chk("rstw.busy", {31'b0, lsu_busy}, 32'd0);
        chk("rstw.done", {31'b0, lsu_done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstw.mem0", mem[0], 32'h8899AABB);
        issue("lw0r",  0, 2'b10, 0, 32'h0, 0, 0, 32'h8899AABB, 3, 2, 4'b0, 0, 1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got time limit want finish");
        $fatal(1, "watchdog");
    end

endmodule
